// File: rtl/wb_dma_engine_if.sv
// Wishbone classic bus bundle. The DMA uses one instance as its register
// responder port and another as its copy master port.
interface wb_dma_engine_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          cyc;
   logic          stb;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] dat_w;
   logic [DW-1:0] dat_r;
   logic          ack;

   modport master (output cyc, stb, we, addr, dat_w, input dat_r, ack);
   modport slave  (input cyc, stb, we, addr, dat_w, output dat_r, ack);
endinterface

// File: rtl/wb_dma_engine.sv
// Word-copy DMA engine: register responder on cfg, read-then-write Wishbone
// master on m, level interrupt on completion or master timeout.
module wb_dma_engine #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int LEN_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic            clk,
   input  logic            rst,
   wb_dma_engine_if.slave  cfg,
   wb_dma_engine_if.master m,
   output logic            irq_o
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic                  ack_q, ack_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
   logic [ADDR_WIDTH-1:0] wsrc_q, wsrc_d, wdst_q, wdst_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d, rem_q, rem_d;
   logic                  ien_q, ien_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
   logic [DATA_WIDTH-1:0] buf_q, buf_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  m_cyc_q, m_cyc_d, m_we_q, m_we_d;
   logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
   logic [DATA_WIDTH-1:0] m_dat_q, m_dat_d;
   logic                  irq_q, irq_d;

   logic cfg_acc_s, cfg_wr_s, ctrl_wr_s, start_s, abort_s, clear_s;
   logic m_ack_s, tmo_hit_s;
   logic unused_s;

   assign cfg_acc_s = cfg.cyc & cfg.stb & ~ack_q;
   assign cfg_wr_s  = cfg_acc_s & cfg.we;
   assign ctrl_wr_s = cfg_wr_s & (cfg.addr[3:2] == 2'd3);
   assign start_s   = ctrl_wr_s & cfg.dat_w[0];
   assign abort_s   = ctrl_wr_s & cfg.dat_w[1];
   assign clear_s   = ctrl_wr_s & cfg.dat_w[2];
   assign m_ack_s   = m_cyc_q & m.ack;
   assign tmo_hit_s = m_cyc_q & ~m.ack & (tmo_q == TW'(TIMEOUT_CYCLES - 1));
   assign unused_s  = ^{cfg.addr[31:4], cfg.addr[1:0]};

   // Register port decode, flag updates and copy sequencer next state.
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      ien_d    = ien_q;
      done_d   = done_q;
      err_d    = err_q;
      busy_d   = busy_q;
      wsrc_d   = wsrc_q;
      wdst_d   = wdst_q;
      rem_d    = rem_q;
      buf_d    = buf_q;
      m_cyc_d  = m_cyc_q;
      m_we_d   = m_we_q;
      m_addr_d = m_addr_q;
      m_dat_d  = m_dat_q;
      rdata_d  = 32'd0;
      ack_d    = cfg_acc_s;
      tmo_d    = (m_cyc_q && !m.ack) ? tmo_q + TW'(1) : TW'(0);

      if (cfg_acc_s && !cfg.we) begin
         case (cfg.addr[3:2])
            2'd0:    rdata_d = 32'(src_q);
            2'd1:    rdata_d = 32'(dst_q);
            2'd2:    rdata_d = 32'(len_q);
            2'd3:    rdata_d = {16'(rem_q), 12'd0, ien_q, err_q, done_q, busy_q};
            default: rdata_d = 32'd0;
         endcase
      end else begin
         rdata_d = 32'd0;
      end

      // Programming registers are frozen for the duration of a transfer.
      if (cfg_wr_s && !busy_q) begin
         case (cfg.addr[3:2])
            2'd0:    src_d = {cfg.dat_w[ADDR_WIDTH-1:2], 2'b00};
            2'd1:    dst_d = {cfg.dat_w[ADDR_WIDTH-1:2], 2'b00};
            2'd2:    len_d = cfg.dat_w[LEN_WIDTH-1:0];
            default: len_d = len_q;
         endcase
      end else begin
         len_d = len_q;
      end

      if (ctrl_wr_s) begin
         ien_d = cfg.dat_w[3];
      end else begin
         ien_d = ien_q;
      end

      if (clear_s) begin
         done_d = 1'b0;
         err_d  = 1'b0;
      end else begin
         done_d = done_q;
         err_d  = err_q;
      end

      case (state_q)
         S_IDLE: begin
            if (start_s) begin
               done_d = 1'b0;
               err_d  = 1'b0;
               wsrc_d = src_q;
               wdst_d = dst_q;
               rem_d  = len_q;
               if (len_q == '0) begin
                  done_d = 1'b1;
               end else begin
                  busy_d   = 1'b1;
                  state_d  = S_READ;
                  m_cyc_d  = 1'b1;
                  m_we_d   = 1'b0;
                  m_addr_d = src_q;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ, S_WRITE: begin
            // Abort outranks a same-cycle ack, which is then simply dropped.
            if (abort_s) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b0;
               err_d   = 1'b0;
               m_cyc_d = 1'b0;
               m_we_d  = 1'b0;
            end else if (tmo_hit_s) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               err_d   = 1'b1;
               m_cyc_d = 1'b0;
               m_we_d  = 1'b0;
            end else if (state_q == S_READ) begin
               if (m_ack_s) begin
                  buf_d   = m.dat_r;
                  m_cyc_d = 1'b0;
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end else if (!m_cyc_q) begin
               m_cyc_d  = 1'b1;
               m_we_d   = 1'b1;
               m_addr_d = wdst_q;
               m_dat_d  = buf_q;
            end else if (m_ack_s) begin
               wsrc_d = wsrc_q + ADDR_WIDTH'(4);
               wdst_d = wdst_q + ADDR_WIDTH'(4);
               rem_d  = rem_q - LEN_WIDTH'(1);
               m_we_d = 1'b0;
               if (rem_q == LEN_WIDTH'(1)) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  m_cyc_d = 1'b0;
               end else begin
                  state_d  = S_READ;
                  m_addr_d = wsrc_q + ADDR_WIDTH'(4);
               end
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = S_IDLE;
      endcase

      irq_d = ien_d & (done_d | err_d);
   end

   // All state, including the registered bus outputs, clears asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ack_q    <= 1'b0;
         rdata_q  <= 32'd0;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         ien_q    <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         wsrc_q   <= '0;
         wdst_q   <= '0;
         rem_q    <= '0;
         buf_q    <= '0;
         tmo_q    <= '0;
         m_cyc_q  <= 1'b0;
         m_we_q   <= 1'b0;
         m_addr_q <= '0;
         m_dat_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         rdata_q  <= rdata_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         ien_q    <= ien_d;
         done_q   <= done_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         wsrc_q   <= wsrc_d;
         wdst_q   <= wdst_d;
         rem_q    <= rem_d;
         buf_q    <= buf_d;
         tmo_q    <= tmo_d;
         m_cyc_q  <= m_cyc_d;
         m_we_q   <= m_we_d;
         m_addr_q <= m_addr_d;
         m_dat_q  <= m_dat_d;
         irq_q    <= irq_d;
      end
   end

   assign cfg.ack   = ack_q;
   assign cfg.dat_r = rdata_q;
   assign m.cyc     = m_cyc_q;
   assign m.stb     = m_cyc_q;
   assign m.we      = m_we_q;
   assign m.addr    = m_addr_q;
   assign m.dat_w   = m_dat_q;
   assign irq_o     = irq_q;
endmodule

// File: tb/tb_wb_dma_engine.sv
// Directed bench for wb_dma_engine: register-port host tasks plus a word
// memory slave on the master port with programmable ack latency.
module tb_wb_dma_engine;
   logic clk = 1'b0;
   logic rst;
   logic irq;

   wb_dma_engine_if #(.AW(32), .DW(32)) cfg ();
   wb_dma_engine_if #(.AW(32), .DW(32)) mbus ();

   wb_dma_engine #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16), .TIMEOUT_CYCLES(1024)
   ) dut (
      .clk(clk), .rst(rst), .cfg(cfg), .m(mbus), .irq_o(irq)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] mem  [0:1023];
   logic [31:0] wmem [0:1023];
   int          slv_wait;
   logic        noack_en;
   int          wcnt = 0;
   int          n_rd_ack = 0;
   int          n_wr_ack = 0;
   int          cyc_cnt = 0;
   logic [7:0]  op_log;
   logic [31:0] last_rd_addr;
   logic [31:0] last_wr_addr;

   // Memory slave; address 0x300 never acks while noack_en is set.
   always @(posedge clk) begin
      if (rst) begin
         mbus.ack <= 1'b0;
         wcnt     <= 0;
      end else if (mbus.cyc && mbus.stb && !mbus.ack && !(noack_en && mbus.addr == 32'h300)) begin
         if (wcnt >= slv_wait) begin
            mbus.ack <= 1'b1;
            wcnt     <= 0;
            if (mbus.we) wmem[mbus.addr[11:2]] <= mbus.dat_w;
            else         mbus.dat_r <= mem[mbus.addr[11:2]];
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         mbus.ack <= 1'b0;
         wcnt     <= 0;
      end
   end

   always @(posedge clk) begin
      if (!rst && mbus.cyc && mbus.ack) begin
         op_log <= {op_log[6:0], mbus.we};
         if (mbus.we) begin
            n_wr_ack     <= n_wr_ack + 1;
            last_wr_addr <= mbus.addr;
         end else begin
            n_rd_ack     <= n_rd_ack + 1;
            last_rd_addr <= mbus.addr;
         end
      end
   end

   always @(negedge clk) if (mbus.cyc) cyc_cnt <= cyc_cnt + 1;

   task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      cfg.cyc = 1'b1; cfg.stb = 1'b1; cfg.we = 1'b1;
      cfg.addr = {28'd0, a}; cfg.dat_w = d;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (cfg.ack) break;
      end
      n_vec++;
      if (cfg.ack !== 1'b1) begin
         n_err++;
         $display("FAIL cfg_write_ack: ack=%b required 1 (addr %h)", cfg.ack, a);
      end
      cfg.cyc = 1'b0; cfg.stb = 1'b0; cfg.we = 1'b0;
   endtask

   task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      cfg.cyc = 1'b1; cfg.stb = 1'b1; cfg.we = 1'b0; cfg.addr = {28'd0, a};
      d = 32'd0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (cfg.ack) begin
            d = cfg.dat_r;
            break;
         end
      end
      cfg.cyc = 1'b0; cfg.stb = 1'b0;
   endtask

   task automatic wait_idle();
      logic [31:0] s;
      int polls;
      s = 32'h1;
      polls = 0;
      while (s[0] && polls < 400) begin
         cfg_read(4'hC, s);
         polls++;
      end
      if (s[0]) begin
         n_vec++; n_err++;
         $display("FAIL wait_idle: busy=%b after %0d polls, required 0", s[0], polls);
      end
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if ({mbus.cyc, mbus.stb, mbus.we, mbus.addr, mbus.dat_w, cfg.ack, cfg.dat_r, irq} !== 99'd0) begin
         n_err++; $display("FAIL reset_outputs: some output nonzero, required all 0");
      end
      cfg_read(4'hC, rd);
      n_vec++;
      if (rd !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h required 00000000", rd); end
      @(negedge clk);
      n_vec++;
      if (cfg.dat_r !== 32'h0) begin n_err++; $display("FAIL dat_o_idle: got %h required 0", cfg.dat_r); end
   endtask

   task automatic test_copy();
      logic [31:0] rd;
      logic [31:0] exp_w [4];
      int br, bw;
      exp_w = '{32'h11, 32'h22, 32'h33, 32'h44};
      slv_wait = 1;
      cfg_write(4'h0, 32'h103);
      cfg_read(4'h0, rd);
      n_vec++;
      if (rd !== 32'h100) begin n_err++; $display("FAIL src_align: got %h required 00000100", rd); end
      cfg_write(4'h4, 32'h200);
      cfg_write(4'h8, 32'd4);
      br = n_rd_ack; bw = n_wr_ack;
      cfg_write(4'hC, 32'h9);
      wait_idle();
      cfg_read(4'hC, rd);
      n_vec++;
      if (rd !== 32'h0000000A) begin n_err++; $display("FAIL copy_status: got %h required 0000000a", rd); end
      n_vec++;
      if (irq !== 1'b1) begin n_err++; $display("FAIL copy_irq: got %b required 1", irq); end
      n_vec++;
      if ((n_rd_ack - br) != 4 || (n_wr_ack - bw) != 4) begin
         n_err++; $display("FAIL copy_counts: rd %0d wr %0d required 4 4", n_rd_ack - br, n_wr_ack - bw);
      end
      n_vec++;
      if (op_log !== 8'h55) begin n_err++; $display("FAIL copy_order: got %b required 01010101", op_log); end
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (wmem[32 + 128 + i - 32] !== exp_w[i]) begin
            n_err++; $display("FAIL copy_dst[%0d]: got %h required %h", i, wmem[128 + i], exp_w[i]);
         end
      end
      cfg_write(4'hC, 32'h4);
      n_vec++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL clear_irq: got %b required 0", irq); end
   endtask

   task automatic test_zero_len();
      logic [31:0] rd;
      int bc;
      cfg_write(4'h8, 32'd0);
      bc = cyc_cnt;
      cfg_write(4'hC, 32'h1);
      repeat (2) @(negedge clk);
      cfg_read(4'hC, rd);
      n_vec++;
      if (rd !== 32'h00000002) begin n_err++; $display("FAIL zero_len_status: got %h required 00000002", rd); end
      repeat (4) @(negedge clk);
      n_vec++;
      if (cyc_cnt != bc) begin n_err++; $display("FAIL zero_len_cyc: %0d cycles with m_cyc, required 0", cyc_cnt - bc); end
   endtask

   task automatic test_timeout();
      logic [31:0] rd;
      int bc;
      noack_en = 1'b1;
      cfg_write(4'h0, 32'h300);
      cfg_write(4'h4, 32'h380);
      cfg_write(4'h8, 32'd2);
      bc = cyc_cnt;
      cfg_write(4'hC, 32'h9);
      for (int i = 0; i < 1200 && mbus.cyc; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      n_vec++;
      if (mbus.cyc !== 1'b0 || (cyc_cnt - bc) != 1024) begin
         n_err++; $display("FAIL timeout_len: cyc=%b after %0d high cycles, required 0 after 1024", mbus.cyc, cyc_cnt - bc);
      end
      cfg_read(4'hC, rd);
      n_vec++;
      if (rd !== 32'h0002000C) begin n_err++; $display("FAIL timeout_status: got %h required 0002000c", rd); end
      n_vec++;
      if (irq !== 1'b1) begin n_err++; $display("FAIL timeout_irq: got %b required 1", irq); end
      cfg_write(4'hC, 32'hC);
      cfg_read(4'hC, rd);
      n_vec++;
      if (rd !== 32'h00020008 || irq !== 1'b0) begin
         n_err++; $display("FAIL timeout_clear: status %h irq %b required 00020008 0", rd, irq);
      end
      noack_en = 1'b0;
   endtask

   task automatic test_abort();
      logic [31:0] rd;
      int bw;
      slv_wait = 3;
      cfg_write(4'h0, 32'h500);
      cfg_write(4'h4, 32'h600);
      cfg_write(4'h8, 32'd8);
      bw = n_wr_ack;
      cfg_write(4'hC, 32'h1);
      for (int i = 0; i < 300 && (n_wr_ack - bw) < 3; i++) @(negedge clk);
      cfg_write(4'hC, 32'h2);
      n_vec++;
      if (mbus.cyc !== 1'b0) begin n_err++; $display("FAIL abort_drop: cyc=%b required 0", mbus.cyc); end
      repeat (8) @(negedge clk);
      cfg_read(4'hC, rd);
      n_vec++;
      if (rd !== 32'h00050000) begin n_err++; $display("FAIL abort_status: got %h required 00050000", rd); end
      n_vec++;
      if ((n_wr_ack - bw) != 3 || last_wr_addr !== 32'h608) begin
         n_err++; $display("FAIL abort_writes: %0d writes, last %h required 3, 00000608", n_wr_ack - bw, last_wr_addr);
      end
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (wmem[384 + i] !== 32'hA0 + 32'(i)) begin
            n_err++; $display("FAIL abort_dst[%0d]: got %h required %h", i, wmem[384 + i], 32'hA0 + 32'(i));
         end
      end
   endtask

   task automatic test_busy_writes();
      logic [31:0] rd;
      int bw;
      slv_wait = 2;
      cfg_write(4'h0, 32'h700);
      cfg_write(4'h4, 32'h780);
      cfg_write(4'h8, 32'd4);
      bw = n_wr_ack;
      cfg_write(4'hC, 32'h1);
      cfg_write(4'h0, 32'h400);
      cfg_read(4'h0, rd);
      n_vec++;
      if (rd !== 32'h700) begin n_err++; $display("FAIL busy_src: got %h required 00000700", rd); end
      cfg_write(4'hC, 32'h1);
      cfg_read(4'hC, rd);
      n_vec++;
      if (rd[0] !== 1'b1) begin n_err++; $display("FAIL busy_flag: got %b required 1", rd[0]); end
      wait_idle();
      cfg_read(4'hC, rd);
      n_vec++;
      if (rd !== 32'h2 || (n_wr_ack - bw) != 4) begin
         n_err++; $display("FAIL busy_restart: status %h writes %0d required 00000002 4", rd, n_wr_ack - bw);
      end
      n_vec++;
      if (wmem[483] !== 32'h100001C3) begin n_err++; $display("FAIL busy_dst: got %h required 100001c3", wmem[483]); end
   endtask

   task automatic test_wrap();
      logic [31:0] rd;
      slv_wait = 0;
      cfg_write(4'h0, 32'hFFFF_FFF8);
      cfg_write(4'h4, 32'h900);
      cfg_write(4'h8, 32'd3);
      cfg_write(4'hC, 32'h1);
      wait_idle();
      cfg_read(4'hC, rd);
      n_vec++;
      if (rd !== 32'h2) begin n_err++; $display("FAIL wrap_status: got %h required 00000002", rd); end
      n_vec++;
      if (last_rd_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h required 00000000", last_rd_addr); end
      n_vec++;
      if (wmem[576] !== 32'h5A5A0001 || wmem[578] !== 32'h5A5A0003) begin
         n_err++; $display("FAIL wrap_data: got %h %h required 5a5a0001 5a5a0003", wmem[576], wmem[578]);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] rd;
      int bc;
      slv_wait = 5;
      cfg_write(4'h0, 32'h100);
      cfg_write(4'h4, 32'h280);
      cfg_write(4'h8, 32'd4);
      cfg_write(4'hC, 32'h9);
      for (int i = 0; i < 100 && !(mbus.cyc && mbus.we); i++) @(negedge clk);
      n_vec++;
      if (!(mbus.cyc === 1'b1 && mbus.we === 1'b1)) begin
         n_err++; $display("FAIL rst_reach_write: cyc %b we %b required 1 1", mbus.cyc, mbus.we);
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if ({mbus.cyc, mbus.stb, mbus.we, mbus.addr, mbus.dat_w, cfg.ack, cfg.dat_r, irq} !== 99'd0) begin
         n_err++; $display("FAIL rst_async: cyc %b we %b addr %h required all 0", mbus.cyc, mbus.we, mbus.addr);
      end
      @(negedge clk);
      rst = 1'b0;
      bc = cyc_cnt;
      cfg_read(4'hC, rd);
      n_vec++;
      if (rd !== 32'h0) begin n_err++; $display("FAIL rst_status: got %h required 00000000", rd); end
      cfg_read(4'h0, rd);
      n_vec++;
      if (rd !== 32'h0) begin n_err++; $display("FAIL rst_src: got %h required 00000000", rd); end
      repeat (4) @(negedge clk);
      n_vec++;
      if (cyc_cnt != bc) begin n_err++; $display("FAIL rst_idle: %0d cyc cycles required 0", cyc_cnt - bc); end
   endtask

   initial begin
      rst = 1'b1;
      cfg.cyc = 1'b0; cfg.stb = 1'b0; cfg.we = 1'b0;
      cfg.addr = 32'd0; cfg.dat_w = 32'd0;
      slv_wait = 0;
      noack_en = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
      mem[64] = 32'h11; mem[65] = 32'h22; mem[66] = 32'h33; mem[67] = 32'h44;
      for (int i = 0; i < 8; i++) mem[320 + i] = 32'hA0 + 32'(i);
      mem[1022] = 32'h5A5A0001; mem[1023] = 32'h5A5A0002; mem[0] = 32'h5A5A0003;

      test_reset();
      test_copy();
      test_zero_len();
      test_timeout();
      test_abort();
      test_busy_writes();
      test_wrap();
      test_async_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
